// File: rtl/riscv_imem_loader.sv
// Boot loader: receives a little-endian word count and instruction words over a
// byte handshake and writes them to instruction memory from word 0, holding the core.
module riscv_imem_loader #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [7:0]        i_byte,
  input  logic              i_byte_valid,
  output logic              o_byte_ready,
  output logic              o_imem_wr_en,
  output logic [ADDR_W-1:0] o_imem_wr_addr,
  output logic [XLEN-1:0]   o_imem_wr_data,
  output logic              o_core_hold,
  output logic              o_done,
  output logic              o_err
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [32:0] CAP   = 33'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_DONE,
    S_ERR
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [31:0]        len_q, len_d;
  logic [23:0]        shift_q, shift_d;
  logic               ready_d, hold_d, done_d, err_d, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_d;
  logic [XLEN-1:0]    wr_data_d;
  logic               accept;
  logic [31:0]        word;

  // The incoming byte completes the word with the three bytes already collected.
  assign accept = o_byte_ready & i_byte_valid;
  assign word   = {i_byte, shift_q};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and next-output logic; outputs are registered below.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    len_d      = len_q;
    shift_d    = shift_q;
    ready_d    = o_byte_ready;
    hold_d     = o_core_hold;
    done_d     = o_done;
    err_d      = o_err;
    wr_en_d    = 1'b0;
    wr_addr_d  = o_imem_wr_addr;
    wr_data_d  = o_imem_wr_data;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        // Entering DONE one cycle after the final write drops the hold then.
        if (state_q == S_DONE) begin
          done_d = 1'b1;
          hold_d = 1'b0;
        end
        if (i_start) begin
          state_d    = S_LEN;
          byte_cnt_d = '0;
          word_cnt_d = '0;
          wr_addr_d  = '0;
          done_d     = 1'b0;
          err_d      = 1'b0;
          ready_d    = 1'b1;
          hold_d     = 1'b1;
        end
      end

      S_LEN: begin
        if (accept) begin
          shift_d    = word[31:8];
          byte_cnt_d = 2'(byte_cnt_q + 2'd1);
          if (byte_cnt_q == 2'd3) begin
            len_d = word;
            if (word == 32'd0 || {1'b0, word} > CAP) begin
              state_d = S_ERR;
              err_d   = 1'b1;
              ready_d = 1'b0;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          shift_d    = word[31:8];
          byte_cnt_d = 2'(byte_cnt_q + 2'd1);
          if (byte_cnt_q == 2'd3) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = word_cnt_q[ADDR_W-1:0];
            wr_data_d  = XLEN'(word);
            word_cnt_d = CNT_W'(word_cnt_q + 1'b1);
            if (32'(word_cnt_q) + 32'd1 == len_q) begin
              state_d = S_DONE;
              ready_d = 1'b0;
            end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered outputs; reset cancels any pending write strobe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      byte_cnt_q     <= '0;
      word_cnt_q     <= '0;
      len_q          <= '0;
      shift_q        <= '0;
      o_byte_ready   <= 1'b0;
      o_core_hold    <= 1'b0;
      o_done         <= 1'b0;
      o_err          <= 1'b0;
      o_imem_wr_en   <= 1'b0;
      o_imem_wr_addr <= '0;
      o_imem_wr_data <= '0;
    end else begin
      byte_cnt_q     <= byte_cnt_d;
      word_cnt_q     <= word_cnt_d;
      len_q          <= len_d;
      shift_q        <= shift_d;
      o_byte_ready   <= ready_d;
      o_core_hold    <= hold_d;
      o_done         <= done_d;
      o_err          <= err_d;
      o_imem_wr_en   <= wr_en_d;
      o_imem_wr_addr <= wr_addr_d;
      o_imem_wr_data <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_riscv_imem_loader.sv
// Self-checking bench for riscv_imem_loader: cycle vector table for a basic load
// plus hand-written sequences for stalls, length errors, capacity and interference.
module tb_riscv_imem_loader;

  localparam int unsigned AW  = 4;
  localparam int unsigned CAPW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    byte_in;
  logic          valid;
  logic          ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          hold;
  logic          done;
  logic          err;
  logic [4:0]    outs;

  always #5 clk = ~clk;

  riscv_imem_loader #(.XLEN(32), .ADDR_W(AW)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_byte        (byte_in),
    .i_byte_valid  (valid),
    .o_byte_ready  (ready),
    .o_imem_wr_en  (wr_en),
    .o_imem_wr_addr(wr_addr),
    .o_imem_wr_data(wr_data),
    .o_core_hold   (hold),
    .o_done        (done),
    .o_err         (err)
  );

  // Packed view of the level outputs: {ready, wr_en, hold, done, err}.
  assign outs = {ready, wr_en, hold, done, err};

  int checks = 0;
  int errors = 0;
  int ready_low = 0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;
  wr_t  wlog[$];
  logic prev_wr = 1'b0;

  typedef struct {
    logic        start;
    logic        valid;
    logic [7:0]  b;
    logic [4:0]  exp_out;
    logic [AW-1:0] exp_addr;
    logic [31:0] exp_data;
  } vec_t;
  vec_t vq[$];

  // Write monitor: logs every strobe and flags strobes longer than one cycle.
  always @(negedge clk) begin
    if (rst) begin
      prev_wr <= 1'b0;
    end else begin
      if (wr_en) begin
        wlog.push_back({wr_addr, wr_data});
        checks++;
        if (prev_wr) begin
          errors++;
          $display("FAIL strobe_width: wr_en high two cycles in a row at addr %0d", wr_addr);
        end
      end
      prev_wr <= wr_en;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    byte_in = b;
    valid   = 1'b1;
    while (!ready && n < 20) begin
      ready_low++;
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: ready stayed 0 for byte %h", b);
    end
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int i = 0; i < 4; i++)
      send_byte(w[8*i +: 8], $urandom_range(0, maxgap));
  endtask

  task automatic wait_end(input string name);
    int n = 0;
    while (!(done | err) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_end"}, 64'(done | err), 64'd1);
  endtask

  task automatic check_log(input string name, input int idx, input logic [AW-1:0] a,
                           input logic [31:0] d);
    if (idx < wlog.size()) check(name, {wlog[idx].a, wlog[idx].d}, {a, d});
    else check({name, "_missing"}, 64'(wlog.size()), 64'(idx + 1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; valid = 1'b0; byte_in = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset: asynchronous clear from a busy state, then quiet while idle.
    start_pulse();
    check("start_hold", outs, 5'b10100);
    #2 rst = 1'b1;
    #1 check("async_reset", outs, 5'b00000);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      valid   = 1'($urandom_range(0, 1));
      byte_in = 8'($urandom);
      @(posedge clk);
      #1 check($sformatf("idle_quiet%0d", i), {outs, wr_addr, wr_data}, '0);
    end
    valid = 1'b0;

    // Basic load, one byte per cycle; first byte offered with the start pulse.
    vq.push_back('{1'b1, 1'b1, 8'h55, 5'b10100, 4'd0, 32'h0});
    vq.push_back('{1'b0, 1'b1, 8'h02, 5'b10100, 4'd0, 32'h0});
    vq.push_back('{1'b0, 1'b1, 8'h00, 5'b10100, 4'd0, 32'h0});
    vq.push_back('{1'b0, 1'b1, 8'h00, 5'b10100, 4'd0, 32'h0});
    vq.push_back('{1'b0, 1'b1, 8'h00, 5'b10100, 4'd0, 32'h0});
    vq.push_back('{1'b0, 1'b1, 8'h93, 5'b10100, 4'd0, 32'h0});
    vq.push_back('{1'b0, 1'b1, 8'h00, 5'b10100, 4'd0, 32'h0});
    vq.push_back('{1'b0, 1'b1, 8'h50, 5'b10100, 4'd0, 32'h0});
    vq.push_back('{1'b0, 1'b1, 8'h00, 5'b11100, 4'd0, 32'h00500093});
    vq.push_back('{1'b0, 1'b1, 8'h13, 5'b10100, 4'd0, 32'h0});
    vq.push_back('{1'b0, 1'b1, 8'h01, 5'b10100, 4'd0, 32'h0});
    vq.push_back('{1'b0, 1'b1, 8'h10, 5'b10100, 4'd0, 32'h0});
    vq.push_back('{1'b0, 1'b1, 8'h00, 5'b01100, 4'd1, 32'h00100113});
    vq.push_back('{1'b0, 1'b0, 8'h00, 5'b00010, 4'd0, 32'h0});
    vq.push_back('{1'b0, 1'b1, 8'hAA, 5'b00010, 4'd0, 32'h0});
    wlog.delete();
    foreach (vq[i]) begin
      @(negedge clk);
      start = vq[i].start; valid = vq[i].valid; byte_in = vq[i].b;
      @(posedge clk);
      #1 start = 1'b0; valid = 1'b0;
      check($sformatf("vec%0d_out", i), outs, vq[i].exp_out);
      if (vq[i].exp_out[3])
        check($sformatf("vec%0d_wr", i), {wr_addr, wr_data}, {vq[i].exp_addr, vq[i].exp_data});
    end
    check("basic_nwr", 64'(wlog.size()), 64'd2);

    // Stalled stream: random gaps must give the identical write sequence.
    wlog.delete();
    start_pulse();
    ready_low = 0;
    send_word(32'd2, 3);
    send_word(32'h00500093, 3);
    send_word(32'h00100113, 3);
    wait_end("stall");
    check("stall_out", outs, 5'b00010);
    check("stall_nwr", 64'(wlog.size()), 64'd2);
    check_log("stall_w0", 0, 4'd0, 32'h00500093);
    check_log("stall_w1", 1, 4'd1, 32'h00100113);
    check("stall_ready", 64'(ready_low), 64'd0);

    // Length errors: zero and one past capacity.
    for (int k = 0; k < 2; k++) begin
      wlog.delete();
      start_pulse();
      send_word((k == 0) ? 32'd0 : 32'(CAPW + 1), 0);
      @(negedge clk);
      check($sformatf("lenerr%0d_out", k), outs, 5'b00101);
      repeat (3) @(negedge clk);
      check($sformatf("lenerr%0d_hold", k), {outs, 32'(wlog.size())}, {5'b00101, 32'd0});
    end
    start_pulse();
    check("err_clear", outs, 5'b10100);
    send_word(32'd1, 0);
    send_word(32'hDEADBEEF, 0);
    wait_end("after_err");
    check("after_err_out", outs, 5'b00010);
    check("after_err_nwr", 64'(wlog.size()), 64'd1);
    check_log("after_err_w0", 0, 4'd0, 32'hDEADBEEF);

    // Full capacity: data = word index, last address all ones.
    wlog.delete();
    start_pulse();
    send_word(32'(CAPW), 0);
    for (int i = 0; i < CAPW; i++) send_word(32'(i), 0);
    wait_end("full");
    check("full_out", outs, 5'b00010);
    check("full_nwr", 64'(wlog.size()), 64'(CAPW));
    for (int i = 0; i < CAPW; i++) check_log($sformatf("full_w%0d", i), i, AW'(i), 32'(i));

    // Start pulse during DATA is ignored.
    wlog.delete();
    start_pulse();
    send_word(32'd2, 0);
    send_word(32'hAABBCCDD, 0);
    start_pulse();
    send_word(32'h01020304, 0);
    wait_end("intf");
    check("intf_out", outs, 5'b00010);
    check("intf_nwr", 64'(wlog.size()), 64'd2);
    check_log("intf_w0", 0, 4'd0, 32'hAABBCCDD);
    check_log("intf_w1", 1, 4'd1, 32'h01020304);

    // Reset after two bytes of the second word, then a clean reload.
    wlog.delete();
    start_pulse();
    send_word(32'd2, 0);
    send_word(32'h11111111, 0);
    send_byte(8'h77, 0);
    send_byte(8'h66, 0);
    #2 rst = 1'b1;
    #1 check("midword_reset", outs, 5'b00000);
    repeat (2) @(negedge clk);
    check("midword_nwr", 64'(wlog.size()), 64'd1);
    rst = 1'b0;
    wlog.delete();
    start_pulse();
    send_word(32'd1, 0);
    send_word(32'hCAFEF00D, 0);
    wait_end("reload");
    check("reload_out", outs, 5'b00010);
    check("reload_nwr", 64'(wlog.size()), 64'd1);
    check_log("reload_w0", 0, 4'd0, 32'hCAFEF00D);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_imem_loader.md
# riscv_imem_loader

Boot-time loader that fills the instruction memory over a byte-stream handshake while the core is held. After a start pulse it receives a little-endian 32-bit word count and then that many little-endian instruction words. It issues one single-cycle write per word to the instruction memory write port at consecutive word addresses starting at 0, then signals completion and releases the core. It sits between a host byte source (UART receiver or testbench) and the instruction memory write port.

## Interface

- XLEN, 32: instruction word width; only 32 is supported.
- ADDR_W, `IMEM_ADDR_BIT-2`: word-address width of the instruction memory; capacity is 2**ADDR_W words.

- i_clk  input  1  system clock; all state changes on the rising edge.
- i_rst  input  1  reset, asynchronous and active-high.
- i_start  input  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- i_byte  input  8  stream data byte.
- i_byte_valid  input  1  i_byte is valid.
- o_byte_ready  output  1  loader accepts a byte; a byte transfers on an edge where valid and ready are both 1.
- o_imem_wr_en  output  1  single-cycle write strobe.
- o_imem_wr_addr  output  ADDR_W  word address of the write.
- o_imem_wr_data  output  XLEN  assembled instruction word.
- o_core_hold  output  1  keeps the core stalled/in reset while loading.
- o_done  output  1  load completed successfully; level signal.
- o_err  output  1  invalid length header; level signal.

## Operation

- States: IDLE, LEN, DATA, DONE, ERR.
- Reset (asynchronous) forces:
  - state IDLE, byte counter 0, word counter 0;
  - all outputs 0, including o_core_hold;
  - any partially written memory contents are left as they are.
- IDLE/DONE/ERR, on i_start:
  - go to LEN;
  - clear the byte counter, word counter, write address, o_done and o_err.
- LEN:
  - accept 4 bytes; the first byte lands in bits [7:0], the last in [31:24]; this gives N.
  - After the 4th byte: if N == 0 or N > 2**ADDR_W, go to ERR; otherwise go to DATA.
- DATA:
  - accept bytes little-endian into a 32-bit shift/assembly register.
  - After every 4th byte, write the word at the current word address, then increment the address.
  - After word N is written, go to DONE.
- The write address never wraps, because N ≤ 2**ADDR_W is checked. Word index N-1 = 2**ADDR_W-1 is legal.
- o_byte_ready: 1 in LEN and DATA; 0 in IDLE, DONE and ERR.
- o_core_hold: 1 from entry to LEN until entry to DONE; stays 1 in ERR; 0 in IDLE and DONE.
- i_start in LEN or DATA is ignored.
- i_byte_valid outside LEN/DATA is ignored; no byte is consumed.

## Timing

- Byte acceptance: at most one byte per cycle. Gaps in i_byte_valid stall the loader with no state change.
- Write latency:
  - the 4th byte of a word is accepted at edge k;
  - o_imem_wr_en = 1 for exactly the cycle following edge k;
  - wr_addr and wr_data are registered and stable in that cycle.
- Back-to-back words: the first byte of the next word may be accepted in the same cycle as the write pulse (ready stays 1). Full throughput is 4 cycles per word.
- Completion:
  - on the final write pulse, o_core_hold is still 1;
  - at the next edge o_done rises and o_core_hold falls.
- Error: the 4th length byte is accepted at edge k; o_err = 1 and o_byte_ready = 0 from the cycle after edge k. No write is ever issued.
- i_start in the same cycle as i_byte_valid while in IDLE: the byte is not accepted. o_byte_ready rises the cycle after the i_start edge.
- o_done and o_err hold until the next accepted i_start or reset. They are never both 1.
- Reset asserted mid-word: the in-flight write pulse is cancelled immediately (asynchronous). The partial word is discarded.

## Test plan

- Reset values: assert i_rst mid-cycle. All outputs are 0 immediately, and remain 0 with i_start low and random i_byte_valid.
- Basic load:
  - stimulus: i_start, then bytes 02 00 00 00 93 00 50 00 13 01 10 00, one per cycle;
  - required: writes addr 0 = 0x00500093 and addr 1 = 0x00100113, each a 1-cycle strobe one cycle after its 4th byte;
  - then o_done = 1 and o_core_hold = 0 one cycle after the second strobe.
- Stalled stream: same bytes with random 0–3 idle cycles between them. The identical write sequence results; no extra strobes; o_byte_ready is 1 throughout LEN and DATA.
- Length errors:
  - N = 0 gives o_err = 1, o_core_hold = 1, ready = 0 and zero writes;
  - the same holds for N = 2**ADDR_W+1;
  - a following i_start with N = 1 completes normally with o_err cleared.
- Full capacity:
  - N = 2**ADDR_W with data = word index;
  - last write has addr = all ones; no wrap;
  - o_done asserts after exactly 2**ADDR_W strobes.
- Interference:
  - i_start pulsed during DATA is ignored and the load completes;
  - i_rst asserted after 2 bytes of word 1 brings all outputs to 0 with no strobe;
  - a subsequent load writes from addr 0 with correct byte alignment.
